// File: rtl/nn_pkg.sv
// Shared definitions for the convolution system: default bus widths and the
// result-drain FSM state encoding used by conv_result_drain and its bench.
package nn_pkg;

   localparam int NN_ADDR_W = 3;
   localparam int NN_DATA_W = 16;

   typedef logic [2:0] drn_state_t;

   localparam drn_state_t DRN_IDLE     = 3'd0;
   localparam drn_state_t DRN_GO       = 3'd1;
   localparam drn_state_t DRN_WAIT_FIN = 3'd2;
   localparam drn_state_t DRN_RD_ISSUE = 3'd3;
   localparam drn_state_t DRN_RD_CAPT  = 3'd4;
   localparam drn_state_t DRN_PRESENT  = 3'd5;
   localparam drn_state_t DRN_DONE     = 3'd6;
   localparam drn_state_t DRN_ERROR    = 3'd7;

   // Busy covers every state in which a run is in flight.
   function automatic logic drn_is_busy(input drn_state_t st);
      logic b;
      case (st)
         DRN_IDLE, DRN_DONE, DRN_ERROR: b = 1'b0;
         default:                       b = 1'b1;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/drain_out_reg.sv
// Output holding register for the result drain: captures one RAM word with
// its index/last tag and holds it stable on the valid/ready port until taken.
module drain_out_reg
   import nn_pkg::*;
#(
   parameter int ADDR_W = NN_ADDR_W,
   parameter int DATA_W = NN_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic [ADDR_W-1:0] load_index,
   input  logic              load_last,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] index,
   output logic              last
);

   // Load a new word, or drop valid once the sink has taken the current one.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= {DATA_W{1'b0}};
         index <= {ADDR_W{1'b0}};
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         index <= load_index;
         last  <= load_last;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

endmodule

// File: rtl/conv_result_drain.sv
// Host-side result drain: pulses go, waits (bounded) for finish, then reads
// NUM_WORDS words from the output RAM one at a time and streams them out.
// Optional build macro: DRAIN_CHECKSUM_EN adds checksum/checksum_valid outputs.
module conv_result_drain
   import nn_pkg::*;
#(
   parameter int ADDR_W         = NN_ADDR_W,
   parameter int DATA_W         = NN_DATA_W,
   parameter int NUM_WORDS      = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              xxx__dut__go,
   input  logic              dut__xxx__finish,
   output logic [ADDR_W-1:0] drn__dom__address,
   output logic              drn__dom__enable,
   input  logic [DATA_W-1:0] dom__drn__data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              busy,
   output logic              timeout_err
`ifdef DRAIN_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum,
   output logic              checksum_valid
`endif
);

   localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   drn_state_t        state_r, state_next_s;
   logic [ADDR_W-1:0] idx_r, idx_next_s;
   logic [TMR_W-1:0]  timer_r, timer_next_s;
   logic              accept_s;
   logic              load_s;
   logic              last_s;

   assign accept_s = out_valid & out_ready;
   assign load_s   = (state_r == DRN_RD_CAPT);
   assign last_s   = (idx_r == IDX_LAST);

   // Next-state, word index and finish-timer logic.
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      timer_next_s = {TMR_W{1'b0}};
      case (state_r)
         DRN_IDLE, DRN_DONE, DRN_ERROR: begin
            if (start) begin
               state_next_s = DRN_GO;
               idx_next_s   = {ADDR_W{1'b0}};
            end else begin
               state_next_s = state_r;
            end
         end
         DRN_GO: state_next_s = DRN_WAIT_FIN;
         DRN_WAIT_FIN: begin
            // finish is checked first so it wins over a same-cycle timeout
            if (dut__xxx__finish) begin
               state_next_s = DRN_RD_ISSUE;
            end else if (timer_r == TMR_LAST) begin
               state_next_s = DRN_ERROR;
            end else begin
               state_next_s = DRN_WAIT_FIN;
               timer_next_s = timer_r + TMR_ONE;
            end
         end
         DRN_RD_ISSUE: state_next_s = DRN_RD_CAPT;
         DRN_RD_CAPT:  state_next_s = DRN_PRESENT;
         DRN_PRESENT: begin
            if (accept_s) begin
               if (last_s) begin
                  state_next_s = DRN_DONE;
               end else begin
                  state_next_s = DRN_RD_ISSUE;
                  idx_next_s   = idx_r + IDX_ONE;
               end
            end else begin
               state_next_s = DRN_PRESENT;
            end
         end
         default: state_next_s = DRN_IDLE;
      endcase
   end

   // State, counters and registered control outputs (decoded from next state).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r           <= DRN_IDLE;
         idx_r             <= {ADDR_W{1'b0}};
         timer_r           <= {TMR_W{1'b0}};
         xxx__dut__go      <= 1'b0;
         drn__dom__enable  <= 1'b0;
         drn__dom__address <= {ADDR_W{1'b0}};
         busy              <= 1'b0;
         timeout_err       <= 1'b0;
      end else begin
         state_r          <= state_next_s;
         idx_r            <= idx_next_s;
         timer_r          <= timer_next_s;
         xxx__dut__go     <= (state_next_s == DRN_GO);
         drn__dom__enable <= (state_next_s == DRN_RD_ISSUE);
         busy             <= drn_is_busy(state_next_s);
         if (state_next_s == DRN_RD_ISSUE) begin
            drn__dom__address <= idx_next_s;
         end else begin
            drn__dom__address <= drn__dom__address;
         end
         if (state_next_s == DRN_ERROR) begin
            timeout_err <= 1'b1;
         end else if (state_next_s == DRN_GO) begin
            timeout_err <= 1'b0;
         end else begin
            timeout_err <= timeout_err;
         end
      end
   end

   drain_out_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk        (clk),
      .reset      (reset),
      .load       (load_s),
      .load_data  (dom__drn__data),
      .load_index (idx_r),
      .load_last  (last_s),
      .ready      (out_ready),
      .valid      (out_valid),
      .data       (out_data),
      .index      (out_index),
      .last       (out_last)
   );

`ifdef DRAIN_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_r;
   logic              checksum_valid_r;

   // Running modulo sum of accepted words, restarted on every launch.
   always_ff @(posedge clk) begin
      if (reset) begin
         checksum_r       <= {DATA_W{1'b0}};
         checksum_valid_r <= 1'b0;
      end else begin
         if (state_next_s == DRN_GO) begin
            checksum_r <= {DATA_W{1'b0}};
         end else if (accept_s) begin
            checksum_r <= checksum_r + out_data;
         end else begin
            checksum_r <= checksum_r;
         end
         checksum_valid_r <= (state_next_s == DRN_DONE);
      end
   end

   assign checksum       = checksum_r;
   assign checksum_valid = checksum_valid_r;
`endif

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain: a RAM model feeds the drain, a
// scoreboard queue holds the words each run should produce, and a negedge
// monitor compares every presented word against the queue head.
module tb_conv_result_drain;
   import nn_pkg::*;

   localparam int AW = 3;
   localparam int DW = 16;
   localparam int NW = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [AW-1:0] idx;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          finish = 1'b0;
   logic          go;
   logic [AW-1:0] dom_addr;
   logic          dom_en;
   logic [DW-1:0] dom_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_index;
   logic          out_last;
   logic          busy;
   logic          timeout_err;

   logic          to_start = 1'b0;
   logic          to_finish = 1'b0;
   logic          to_go;
   logic [AW-1:0] to_addr;
   logic          to_en;
   logic [DW-1:0] to_rdata = '0;
   logic          to_valid;
   logic          to_ready = 1'b1;
   logic [DW-1:0] to_data;
   logic [AW-1:0] to_index;
   logic          to_last;
   logic          to_busy;
   logic          to_err;
`ifdef DRAIN_CHECKSUM_EN
   logic [DW-1:0] checksum, to_checksum;
   logic          checksum_valid, to_checksum_valid;
`endif

   logic [DW-1:0] mem [NW];
   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            acc_count = 0;
   int            stall_count = 0;

   always #5 clk = ~clk;

   conv_result_drain #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .TIMEOUT_CYCLES(1024)) u_dut (
      .clk(clk), .reset(reset), .start(start), .xxx__dut__go(go), .dut__xxx__finish(finish),
      .drn__dom__address(dom_addr), .drn__dom__enable(dom_en), .dom__drn__data(dom_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
      .out_last(out_last), .busy(busy), .timeout_err(timeout_err)
`ifdef DRAIN_CHECKSUM_EN
      , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
   );

   conv_result_drain #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .TIMEOUT_CYCLES(16)) u_to (
      .clk(clk), .reset(reset), .start(to_start), .xxx__dut__go(to_go), .dut__xxx__finish(to_finish),
      .drn__dom__address(to_addr), .drn__dom__enable(to_en), .dom__drn__data(to_rdata),
      .out_valid(to_valid), .out_ready(to_ready), .out_data(to_data), .out_index(to_index),
      .out_last(to_last), .busy(to_busy), .timeout_err(to_err)
`ifdef DRAIN_CHECKSUM_EN
      , .checksum(to_checksum), .checksum_valid(to_checksum_valid)
`endif
   );

   // Output RAM model: registered read, data valid the cycle after enable.
   always @(posedge clk) begin
      if (dom_en) dom_data <= mem[dom_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every presented word must match the queue head.
   always @(negedge clk) begin
      if (reset !== 1'b1 && out_valid === 1'b1) begin
         chk("sb_has_entry", {31'd0, (sb_q.size() != 0)}, 32'd1);
         if (sb_q.size() != 0) begin
            chk("sb_data",  {16'd0, out_data},  {16'd0, sb_q[0].data});
            chk("sb_index", {29'd0, out_index}, {29'd0, sb_q[0].idx});
            chk("sb_last",  {31'd0, out_last},  {31'd0, sb_q[0].last});
            if (out_ready === 1'b1) begin
               void'(sb_q.pop_front());
               acc_count++;
            end else begin
               stall_count++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic put_word(input int i, input logic [DW-1:0] v);
      exp_t e;
      mem[i] = v;
      e.data = v;
      e.idx  = AW'(i);
      e.last = (i == NW - 1);
      sb_q.push_back(e);
   endtask

   task automatic load_and_expect(input logic [DW-1:0] base, input logic [DW-1:0] step);
      for (int i = 0; i < NW; i++) put_word(i, base + DW'(i) * step);
   endtask

   task automatic pulse_start();
      tick(); start = 1'b1;
      tick(); start = 1'b0;
   endtask

   task automatic do_finish();
      tick(); finish = 1'b1;
      tick(); finish = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready high one cycle in four
   task automatic wait_idle(input int budget, input int mode, input string tag);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         tick();
         out_ready = (mode == 0) ? 1'b1 : ((i % 4) == 3);
         samp();
         if (busy === 1'b0) done = 1'b1;
      end
      chk({tag, "_reached_idle"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int  base;
      bit  go_seen, en_seen, valid_seen, found;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      samp();
      chk("rst_go",       {31'd0, go},          32'd0);
      chk("rst_enable",   {31'd0, dom_en},      32'd0);
      chk("rst_valid",    {31'd0, out_valid},   32'd0);
      chk("rst_busy",     {31'd0, busy},        32'd0);
      chk("rst_timeout",  {31'd0, timeout_err}, 32'd0);
      chk("rst_addr",     {29'd0, dom_addr},    32'd0);
      chk("rst_data",     {16'd0, out_data},    32'd0);
      tick(); reset = 1'b0;

      // 1: start -> single go pulse, busy, no RAM reads while waiting
      load_and_expect(16'h0001, 16'h0001);
      out_ready = 1'b1;
      pulse_start();
      samp();
      chk("t1_go_high",   {31'd0, go},     32'd1);
      chk("t1_busy",      {31'd0, busy},   32'd1);
      chk("t1_enable_lo", {31'd0, dom_en}, 32'd0);
      go_seen = 1'b0; en_seen = 1'b0; valid_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         start = (i == 10);   // start while busy must be ignored
         samp();
         go_seen    |= go;
         en_seen    |= dom_en;
         valid_seen |= out_valid;
      end
      chk("t1_go_once",      {31'd0, go_seen},    32'd0);
      chk("t1_no_enable",    {31'd0, en_seen},    32'd0);
      chk("t1_no_valid",     {31'd0, valid_seen}, 32'd0);
      chk("t1_busy_waiting", {31'd0, busy},       32'd1);

      // 2: finish -> 3-cycle latency, 8 words with ready held high
      base = acc_count;
      do_finish();
      samp();
      chk("t2_enable",  {31'd0, dom_en},    32'd1);
      chk("t2_addr0",   {29'd0, dom_addr},  32'd0);
      chk("t2_valid_1", {31'd0, out_valid}, 32'd0);
      tick(); samp();
      chk("t2_enable_1cyc", {31'd0, dom_en},    32'd0);
      chk("t2_valid_2",     {31'd0, out_valid}, 32'd0);
      tick(); samp();
      chk("t2_valid_3", {31'd0, out_valid}, 32'd1);
      wait_idle(100, 0, "t2");
      chk("t2_words",    acc_count - base,          32'd8);
      chk("t2_sb_empty", sb_q.size(),               32'd0);
      chk("t2_busy",     {31'd0, busy},             32'd0);
      chk("t2_valid_lo", {31'd0, out_valid},        32'd0);

      // 3: sparse ready -> no loss/duplication, stable data while stalled
      load_and_expect(16'hA000, 16'h0111);
      out_ready = 1'b0;
      base = acc_count;
      stall_count = 0;
      pulse_start();
      samp();
      chk("t3_go_from_done", {31'd0, go}, 32'd1);
      repeat (5) tick();
      do_finish();
      wait_idle(300, 1, "t3");
      chk("t3_words",    acc_count - base,             32'd8);
      chk("t3_sb_empty", sb_q.size(),                  32'd0);
      chk("t3_stalled",  {31'd0, (stall_count > 0)},   32'd1);

      // 5: reset while presenting idx 3, then full rerun from idx 0
      load_and_expect(16'h5000, 16'h0003);
      out_ready = 1'b1;
      pulse_start();
      repeat (3) tick();
      do_finish();
      base = acc_count;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         out_ready = (acc_count < base + 3);
         samp();
         if (out_valid === 1'b1 && out_index === 3'd3 && out_ready === 1'b0) found = 1'b1;
      end
      chk("t5_reached_idx3", {31'd0, found}, 32'd1);
      tick(); reset = 1'b1; sb_q.delete();
      tick(); samp();
      chk("t5_rst_valid",  {31'd0, out_valid}, 32'd0);
      chk("t5_rst_enable", {31'd0, dom_en},    32'd0);
      chk("t5_rst_busy",   {31'd0, busy},      32'd0);
      tick(); reset = 1'b0;
      out_ready = 1'b1;
      load_and_expect(16'h6000, 16'h0010);
      base = acc_count;
      pulse_start();
      repeat (2) tick();
      do_finish();
      wait_idle(100, 0, "t5");
      chk("t5_words",    acc_count - base, 32'd8);
      chk("t5_sb_empty", sb_q.size(),      32'd0);

      // 4: finish never arrives, 16-cycle timeout on the second instance
      tick(); to_start = 1'b1;
      tick(); to_start = 1'b0;
      samp();
      chk("t4_go", {31'd0, to_go}, 32'd1);
      repeat (16) begin tick(); samp(); end
      chk("t4_err_not_yet", {31'd0, to_err},  32'd0);
      chk("t4_busy_16",     {31'd0, to_busy}, 32'd1);
      tick(); samp();
      chk("t4_err_set",  {31'd0, to_err},  32'd1);
      chk("t4_idle_err", {31'd0, to_busy}, 32'd0);
      tick(); to_start = 1'b1;
      tick(); to_start = 1'b0;
      samp();
      chk("t4_err_cleared", {31'd0, to_err}, 32'd0);
      chk("t4_rego",        {31'd0, to_go},  32'd1);

`ifdef DRAIN_CHECKSUM_EN
      // 6: checksum wraps modulo 2**DATA_W
      put_word(0, 16'hFFFF);
      put_word(1, 16'h0002);
      for (int i = 2; i < NW; i++) put_word(i, 16'h0000);
      pulse_start();
      samp();
      chk("t6_cv_busy", {31'd0, checksum_valid}, 32'd0);
      do_finish();
      wait_idle(100, 0, "t6");
      chk("t6_checksum", {16'd0, checksum},       32'h0001);
      chk("t6_cv_done",  {31'd0, checksum_valid}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
